// File: rtl/spm_mem_responder.sv
// spm_mem_responder
// Memory-side responder for the SPM controller bus. Holds the address
// register, services CPU reads and writes, and provides a byte-stream
// program loader that fills memory while the CPU is held halted.
// Loader frame: start address, count, then count data bytes written to
// consecutive addresses (wrapping modulo depth).

module spm_mem_responder #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_addr,
  input  logic              write,
  input  logic [DATA_W-1:0] bus1,
  output logic [DATA_W-1:0] mem_word,
  output logic [ADDR_W-1:0] addr_reg,
  input  logic              prog_en,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              ld_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    L_IDLE,
    L_ADDR,
    L_CNT,
    L_DATA,
    L_DONE
  } ld_state_t;

  ld_state_t         ld_state;
  logic [ADDR_W-1:0] ld_ptr;
  logic [7:0]        ld_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic ld_accept;
  logic ld_wr;
  logic cpu_wr;

  // A byte is only taken while prog_en is still high; on the cycle prog_en
  // drops the frame aborts and any byte offered that cycle is discarded.
  assign ld_accept = ld_valid & ld_ready & prog_en;
  assign ld_wr     = ld_accept & (ld_state == L_DATA);
  assign cpu_wr    = write & ~prog_en;

  assign mem_word = mem[addr_reg];

  // Single write port; loader and CPU writes are mutually exclusive via prog_en.
  always_ff @(posedge clk) begin
    if (ld_wr) begin
      mem[ld_ptr] <= DATA_W'(ld_data);
    end else if (cpu_wr) begin
      mem[addr_reg] <= bus1;
    end
  end

  // Address register; a same-edge write above still sees the old address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg <= '0;
    end else if (load_addr) begin
      addr_reg <= ADDR_W'(bus1);
    end
  end

  // Loader FSM with registered handshake and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_state <= L_IDLE;
      ld_ptr   <= '0;
      ld_cnt   <= '0;
      ld_ready <= 1'b0;
      ld_busy  <= 1'b0;
      ld_done  <= 1'b0;
      ld_err   <= 1'b0;
    end else begin
      ld_done <= 1'b0;
      ld_err  <= 1'b0;
      case (ld_state)
        L_IDLE: begin
          if (prog_en) begin
            ld_state <= L_ADDR;
            ld_ready <= 1'b1;
            ld_busy  <= 1'b0;
          end
        end
        L_ADDR: begin
          if (!prog_en) begin
            ld_state <= L_IDLE;
            ld_ready <= 1'b0;
            ld_busy  <= 1'b0;
            ld_err   <= 1'b1;
          end else if (ld_accept) begin
            ld_ptr   <= ADDR_W'(ld_data);
            ld_state <= L_CNT;
            ld_busy  <= 1'b1;
          end
        end
        L_CNT: begin
          if (!prog_en) begin
            ld_state <= L_IDLE;
            ld_ready <= 1'b0;
            ld_busy  <= 1'b0;
            ld_err   <= 1'b1;
          end else if (ld_accept) begin
            ld_cnt <= ld_data;
            if (ld_data == 8'd0) begin
              ld_state <= L_DONE;
              ld_ready <= 1'b0;
              ld_busy  <= 1'b0;
              ld_done  <= 1'b1;
            end else begin
              ld_state <= L_DATA;
            end
          end
        end
        L_DATA: begin
          if (!prog_en) begin
            ld_state <= L_IDLE;
            ld_ready <= 1'b0;
            ld_busy  <= 1'b0;
            ld_err   <= 1'b1;
          end else if (ld_accept) begin
            ld_ptr <= ld_ptr + 1'b1;
            ld_cnt <= ld_cnt - 8'd1;
            if (ld_cnt == 8'd1) begin
              ld_state <= L_DONE;
              ld_ready <= 1'b0;
              ld_busy  <= 1'b0;
              ld_done  <= 1'b1;
            end
          end
        end
        L_DONE: begin
          ld_state <= L_IDLE;
          ld_ready <= 1'b0;
          ld_busy  <= 1'b0;
        end
        default: begin
          ld_state <= L_IDLE;
          ld_ready <= 1'b0;
          ld_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spm_mem_responder.sv
// tb_spm_mem_responder
// Directed and randomized stimulus for spm_mem_responder, checked against
// a plain array model of the memory and the frame rules of the loader.

module tb_spm_mem_responder;

  logic       clk;
  logic       rst;
  logic       load_addr;
  logic       write;
  logic [7:0] bus1;
  logic [7:0] mem_word;
  logic [7:0] addr_reg;
  logic       prog_en;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       ld_busy;
  logic       ld_done;
  logic       ld_err;

  logic [7:0] ref_mem [256];
  int total;
  int bad;
  int frames_done;
  int done_seen;
  int err_seen;
  int both_seen;

  spm_mem_responder #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_addr (load_addr),
    .write     (write),
    .bus1      (bus1),
    .mem_word  (mem_word),
    .addr_reg  (addr_reg),
    .prog_en   (prog_en),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .ld_busy   (ld_busy),
    .ld_done   (ld_done),
    .ld_err    (ld_err)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count status pulses mid-cycle so a stretched pulse is counted twice.
  initial begin
    done_seen = 0;
    err_seen  = 0;
    both_seen = 0;
  end
  always @(negedge clk) begin
    if (!rst) begin
      if (ld_done === 1'b1) done_seen++;
      if (ld_err === 1'b1) err_seen++;
      if (ld_done === 1'b1 && ld_err === 1'b1) both_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic la, input logic wr, input logic [7:0] b);
    load_addr = la;
    write     = wr;
    bus1      = b;
    tick();
    load_addr = 1'b0;
    write     = 1'b0;
  endtask

  task automatic readCheck(input logic [7:0] a, input string tag);
    applyStimulus(1'b1, 1'b0, a);
    checkOutput($sformatf("%s@%02h", tag, a), 16'(mem_word), 16'(ref_mem[a]));
  endtask

  // Stream one complete frame; CPU writes are attempted throughout and must be ignored.
  task automatic sendFrame(input logic [7:0] a, input logic [7:0] data[$], input bit gaps, input string tag);
    logic [7:0] bytes[$];
    logic [7:0] held_addr;
    bit last;
    held_addr = addr_reg;
    bytes.push_back(a);
    bytes.push_back(8'(data.size()));
    foreach (data[i]) begin
      bytes.push_back(data[i]);
      ref_mem[8'(a + 8'(i))] = data[i];
    end
    prog_en = 1'b1;
    tick();
    for (int i = 0; i < bytes.size(); i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        ld_valid = 1'b0;
        write    = 1'b1;
        bus1     = 8'($urandom);
        tick();
        write = 1'b0;
      end
      checkOutput({tag, " ready"}, 16'(ld_ready), 16'd1);
      ld_valid = 1'b1;
      ld_data  = bytes[i];
      write    = 1'b1;
      bus1     = 8'($urandom);
      tick();
      ld_valid = 1'b0;
      write    = 1'b0;
      last = (i == bytes.size() - 1);
      checkOutput({tag, " busy"}, 16'(ld_busy), last ? 16'd0 : 16'd1);
      checkOutput({tag, " done"}, 16'(ld_done), last ? 16'd1 : 16'd0);
    end
    prog_en = 1'b0;
    tick();
    frames_done++;
    checkOutput({tag, " done_clr"}, 16'(ld_done), 16'd0);
    checkOutput({tag, " ready_idle"}, 16'(ld_ready), 16'd0);
    checkOutput({tag, " addr_kept"}, 16'(addr_reg), 16'(held_addr));
  endtask

  // Directed sequence followed by randomized frames and a full memory sweep.
  initial begin
    logic [7:0] q[$];
    logic [7:0] a;
    int n;
    total       = 0;
    bad         = 0;
    frames_done = 0;
    rst       = 1'b1;
    load_addr = 1'b0;
    write     = 1'b0;
    bus1      = 8'h00;
    prog_en   = 1'b0;
    ld_valid  = 1'b0;
    ld_data   = 8'h00;

    tick();
    tick();
    rst = 1'b0;
    tick();

    // Asynchronous reset mid-cycle with the loader active.
    applyStimulus(1'b1, 1'b0, 8'h55);
    checkOutput("addr_load", 16'(addr_reg), 16'h55);
    prog_en = 1'b1;
    tick();
    checkOutput("ready_addr", 16'(ld_ready), 16'd1);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("rst addr", 16'(addr_reg), 16'h00);
    checkOutput("rst ready", 16'(ld_ready), 16'd0);
    checkOutput("rst busy", 16'(ld_busy), 16'd0);
    checkOutput("rst done", 16'(ld_done), 16'd0);
    checkOutput("rst err", 16'(ld_err), 16'd0);
    prog_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Fill every location with a random value through the CPU path.
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'($urandom);
      applyStimulus(1'b1, 1'b0, 8'(i));
      applyStimulus(1'b0, 1'b1, ref_mem[i]);
    end
    for (int i = 0; i < 6; i++) readCheck(8'($urandom), "fill");

    // CPU write then read, visible right after the write edge.
    applyStimulus(1'b1, 1'b0, 8'h40);
    applyStimulus(1'b0, 1'b1, 8'hA5);
    ref_mem[8'h40] = 8'hA5;
    checkOutput("cpu_wr 40", 16'(mem_word), 16'hA5);
    readCheck(8'h41, "next");

    // Same-edge load_addr and write: write hits the old address.
    applyStimulus(1'b1, 1'b0, 8'h10);
    applyStimulus(1'b1, 1'b1, 8'h20);
    ref_mem[8'h10] = 8'h20;
    checkOutput("same addr", 16'(addr_reg), 16'h20);
    checkOutput("same word", 16'(mem_word), 16'(ref_mem[8'h20]));
    readCheck(8'h10, "same mem");

    // Wrapping frame with back-to-back bytes.
    q = '{8'h11, 8'h22, 8'h33};
    sendFrame(8'hFE, q, 1'b0, "wrap");
    readCheck(8'hFE, "wrap");
    readCheck(8'hFF, "wrap");
    readCheck(8'h00, "wrap");
    readCheck(8'h01, "wrap");
    readCheck(8'hFD, "wrap");

    // Zero-count frame with valid gaps.
    q.delete();
    sendFrame(8'h80, q, 1'b1, "zero");
    readCheck(8'h80, "zero");

    // Randomized frames with random gaps.
    for (int f = 0; f < 5; f++) begin
      q.delete();
      a = 8'($urandom);
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      sendFrame(a, q, 1'b1, $sformatf("rnd%0d", f));
      for (int i = -1; i <= n; i++) readCheck(8'(a + 8'(i)), "rnd");
    end

    // Abort after one data byte: written byte stays, single error pulse.
    prog_en = 1'b1;
    tick();
    q = '{8'h20, 8'h04, 8'hAA};
    foreach (q[i]) begin
      ld_valid = 1'b1;
      ld_data  = q[i];
      tick();
    end
    ld_valid = 1'b0;
    ref_mem[8'h20] = 8'hAA;
    prog_en = 1'b0;
    tick();
    checkOutput("abort err", 16'(ld_err), 16'd1);
    checkOutput("abort done", 16'(ld_done), 16'd0);
    checkOutput("abort ready", 16'(ld_ready), 16'd0);
    checkOutput("abort busy", 16'(ld_busy), 16'd0);
    tick();
    checkOutput("abort err_clr", 16'(ld_err), 16'd0);
    readCheck(8'h20, "abort");
    readCheck(8'h21, "abort");

    // Reset mid-frame: silent drop, partial write retained.
    prog_en = 1'b1;
    tick();
    q = '{8'h30, 8'h03, 8'h77};
    foreach (q[i]) begin
      ld_valid = 1'b1;
      ld_data  = q[i];
      tick();
    end
    ld_valid = 1'b0;
    ref_mem[8'h30] = 8'h77;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst err", 16'(ld_err), 16'd0);
    checkOutput("midrst busy", 16'(ld_busy), 16'd0);
    checkOutput("midrst addr", 16'(addr_reg), 16'h00);
    prog_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    checkOutput("midrst err_after", 16'(ld_err), 16'd0);
    readCheck(8'h30, "midrst");
    readCheck(8'h31, "midrst");

    // Pulse accounting over the whole run.
    checkOutput("done pulses", 16'(done_seen), 16'(frames_done));
    checkOutput("err pulses", 16'(err_seen), 16'd1);
    checkOutput("done&err", 16'(both_seen), 16'd0);

    // Full memory sweep against the model.
    for (int i = 0; i < 256; i++) readCheck(8'(i), "sweep");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spm_mem_responder.md
# spm_mem_responder

Memory-side responder for the SPM processor's controller bus: holds the 8-bit address register, services controller reads (instruction, operand, address fetches) and writes, and returns the addressed word to the bus-2 memory input. Also provides a byte-stream program-loader port that fills memory while the CPU is held halted. Sits between the controller/datapath and the program/data store.

## Interface
- DATA_W, 8, word width of memory and buses
- ADDR_W, 8, address width; depth = 2**ADDR_W (wraps modulo depth)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- load_addr  input  1  capture bus1 into address register
- write  input  1  write bus1 into mem[addr_reg]
- bus1  input  DATA_W  address/data from mux1 path
- mem_word  output  DATA_W  mem[addr_reg], to bus-2 MEM select
- addr_reg  output  ADDR_W  current address register
- prog_en  input  1  loader mode; blocks CPU writes
- ld_valid  input  1  loader byte valid
- ld_data  input  8  loader byte
- ld_ready  output  1  loader byte accepted when ld_valid & ld_ready
- ld_busy  output  1  loader frame in progress
- ld_done  output  1  one-cycle pulse, frame completed
- ld_err  output  1  one-cycle pulse, frame aborted

## Operation
- Address register: on clk edge with load_addr=1, addr_reg <= bus1[ADDR_W-1:0].
- CPU write: on clk edge with write=1 and prog_en=0, mem[addr_reg] <= bus1, using addr_reg value before any same-edge load_addr update.
- Read: mem_word is combinational mem[addr_reg]; a word written at edge N is visible on mem_word after edge N.
- CPU write while prog_en=1: ignored (memory unchanged), no error.
- Loader frame: byte 0 = start address A, byte 1 = count N, then N data bytes written to A, A+1, ... modulo depth. N=0: frame ends after count byte.
- Loader FSM states: L_IDLE, L_ADDR, L_CNT, L_DATA, L_DONE.
  - L_IDLE: prog_en=1 -> L_ADDR.
  - L_ADDR: accepted byte -> ld_ptr <= byte, L_CNT.
  - L_CNT: accepted byte -> ld_cnt <= byte; byte=0 -> L_DONE, else L_DATA.
  - L_DATA: accepted byte -> mem[ld_ptr] <= byte, ld_ptr+1, ld_cnt-1; ld_cnt reaching 0 -> L_DONE.
  - L_DONE: ld_done=1 for one cycle -> L_IDLE (new frame needs prog_en still high; re-enters L_ADDR next cycle).
- ld_ready=1 in L_ADDR, L_CNT, L_DATA only. ld_busy=1 in L_CNT, L_DATA.
- Abort: prog_en=0 in L_ADDR/L_CNT/L_DATA -> ld_err pulse one cycle, L_IDLE; bytes already written remain.
- Loader does not modify addr_reg.

## Timing
- Reset (async, rst=1): addr_reg=0, loader in L_IDLE, ld_ptr=0, ld_cnt=0, ld_ready=0, ld_busy=0, ld_done=0, ld_err=0; mem_word = mem[0]. Memory contents not reset.
- Reset mid-frame: frame dropped silently (no ld_err), partial writes retained.
- Address latency: load_addr at edge N -> mem_word valid for new address after edge N (controller fetch: load_addr in s1, word sampled by load_ir in s2/s3).
- Write latency: 1 edge. Loader write: 1 edge per accepted byte; sustains 1 byte/cycle.
- ld_done/ld_err registered, exactly one cycle wide; never simultaneous.
- load_addr and write same edge: write goes to old address, then addr_reg updates.

## Test plan
- Reset: assert rst async mid-cycle -> addr_reg=0x00, all loader outputs 0 immediately.
- CPU write/read: load_addr bus1=0x40, next cycle write bus1=0xA5 -> mem_word=0xA5 after write edge; load_addr 0x41 -> mem_word shows mem[0x41].
- Same-edge: addr_reg=0x10, load_addr=1 bus1=0x20 with write=1 -> mem[0x10]=0x20, addr_reg=0x20.
- Loader: prog_en=1, stream 0xFE,0x03,0x11,0x22,0x33 back-to-back -> mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33 (wrap), ld_done one pulse, CPU write during frame ignored.
- Zero count: stream 0x80,0x00 -> ld_done pulse, no memory change; ld_valid gaps tolerated (ld_ready held, no byte lost).
- Abort: stream 0x20,0x04,0xAA then drop prog_en -> mem[0x20]=0xAA, ld_err one pulse, L_IDLE; rst mid-frame -> no ld_err.
